// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the nonce-sweep result reader.
// Defines the reader state encoding, the default sweep size and the result record layout.
package bitcoin_pkg;

  localparam int NUM_NONCES_DEF = 16;
  localparam int IDX_W_DEF      = 8;

  // Word offsets of the result record, relative to result_addr
  localparam logic [15:0] RES_FOUND = 16'd0;
  localparam logic [15:0] RES_NONCE = 16'd1;
  localparam logic [15:0] RES_MIN   = 16'd2;
  localparam logic [15:0] RES_HITS  = 16'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WR0  = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4,
    WR3  = 3'd5,
    DONE = 3'd6
  } state_e;

  function automatic logic word_hits(input logic [31:0] w, input logic [31:0] t);
    return (w < t);
  endfunction

endpackage

// File: rtl/nonce_result_reader_if.sv
// Memory port bundle shared by the hasher and the result reader.
interface nonce_result_reader_if;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (output mem_clk, output mem_we, output mem_addr, output mem_write_data,
                  input  mem_read_data);
  modport slave  (input  mem_clk, input  mem_we, input  mem_addr, input  mem_write_data,
                  output mem_read_data);
endinterface

// File: rtl/nonce_min_tracker.sv
// Running minimum, its index, the hit flag and (with NONCE_HIT_COUNT_EN) a hit counter.
module nonce_min_tracker
  import bitcoin_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             cap_valid_i,
  input  logic [31:0]      word_i,
  input  logic [31:0]      target_i,
  input  logic [IDX_W-1:0] idx_i,
`ifdef NONCE_HIT_COUNT_EN
  output logic [IDX_W:0]   hits_o,
`endif
  output logic             found_o,
  output logic [IDX_W-1:0] best_o,
  output logic [31:0]      min_o
);

  logic             found_q;
  logic [IDX_W-1:0] best_q;
  logic [31:0]      min_q;

  // Strict less-than on the minimum keeps the lowest index on ties
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found_q <= 1'b0;
      best_q  <= {IDX_W{1'b0}};
      min_q   <= 32'hFFFF_FFFF;
    end else if (clear_i) begin
      found_q <= 1'b0;
      best_q  <= {IDX_W{1'b0}};
      min_q   <= 32'hFFFF_FFFF;
    end else if (cap_valid_i) begin
      if (word_hits(word_i, target_i)) begin
        found_q <= 1'b1;
      end
      if (word_i < min_q) begin
        min_q  <= word_i;
        best_q <= idx_i;
      end
    end
  end

`ifdef NONCE_HIT_COUNT_EN
  logic [IDX_W:0] hits_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hits_q <= {(IDX_W+1){1'b0}};
    end else if (clear_i) begin
      hits_q <= {(IDX_W+1){1'b0}};
    end else if (cap_valid_i && word_hits(word_i, target_i)) begin
      hits_q <= hits_q + {{IDX_W{1'b0}}, 1'b1};
    end
  end

  assign hits_o = hits_q;
`endif

  assign found_o = found_q;
  assign best_o  = best_q;
  assign min_o   = min_q;

endmodule

// File: rtl/nonce_result_reader.sv
// Reads NUM_NONCES hash words, tracks hits and the minimum, writes a result record, then signals done.
// Optional NONCE_HIT_COUNT_EN adds a hit count word at result_addr+3.
module nonce_result_reader
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEF,
  parameter int IDX_W      = IDX_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [15:0]            hash_addr,
  input  logic [15:0]            result_addr,
  input  logic [31:0]            target,
  output logic                   done,
  output logic                   found,
  output logic [IDX_W-1:0]       best_nonce,
  nonce_result_reader_if.master  mem
);

  localparam logic [IDX_W:0] N_CNT    = (IDX_W+1)'(NUM_NONCES);
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(NUM_NONCES - 1);

  state_e         state_q, state_d;
  logic [IDX_W:0] rd_cnt_q, rd_cnt_d;
  logic [IDX_W:0] cap_cnt_q, cap_cnt_d;
  logic           cap_en_q, cap_en_d;
  logic [31:0]    target_q, target_d;
  logic           mem_we_q, mem_we_d;
  logic [15:0]    mem_addr_q, mem_addr_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic           done_q, done_d;

  logic             clear_s;
  logic             cap_valid_s;
  logic             found_s;
  logic [IDX_W-1:0] best_s;
  logic [31:0]      min_s;
`ifdef NONCE_HIT_COUNT_EN
  logic [IDX_W:0]   hits_s;
`endif

  nonce_min_tracker #(.IDX_W(IDX_W)) u_tracker (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (clear_s),
    .cap_valid_i (cap_valid_s),
    .word_i      (mem.mem_read_data),
    .target_i    (target_q),
    .idx_i       (cap_cnt_q[IDX_W-1:0]),
`ifdef NONCE_HIT_COUNT_EN
    .hits_o      (hits_s),
`endif
    .found_o     (found_s),
    .best_o      (best_s),
    .min_o       (min_s)
  );

  // State and datapath registers; mem_we clears asynchronously with reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_cnt_q    <= {(IDX_W+1){1'b0}};
      cap_cnt_q   <= {(IDX_W+1){1'b0}};
      cap_en_q    <= 1'b0;
      target_q    <= 32'h0000_0000;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 32'h0000_0000;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      cap_en_q    <= cap_en_d;
      target_q    <= target_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
    end
  end

  // Next-state: pipelined address issue, delayed capture, then the record write burst
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    cap_en_d    = cap_en_q;
    target_d    = target_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    clear_s     = 1'b0;
    cap_valid_s = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        mem_we_d = 1'b0;
        if (start) begin
          target_d   = target;
          mem_addr_d = hash_addr;
          rd_cnt_d   = {{IDX_W{1'b0}}, 1'b1};
          cap_cnt_d  = {(IDX_W+1){1'b0}};
          cap_en_d   = 1'b0;
          clear_s    = 1'b1;
          done_d     = 1'b0;
          state_d    = READ;
        end else begin
          done_d = (state_q == DONE);
        end
      end
      READ: begin
        if (rd_cnt_q < N_CNT) begin
          mem_addr_d = hash_addr + 16'(rd_cnt_q);
          rd_cnt_d   = rd_cnt_q + {{IDX_W{1'b0}}, 1'b1};
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
        // Data for the first address only arrives on the second READ edge
        cap_en_d = 1'b1;
        if (cap_en_q) begin
          cap_valid_s = 1'b1;
          cap_cnt_d   = cap_cnt_q + {{IDX_W{1'b0}}, 1'b1};
          if (cap_cnt_q == LAST_IDX) begin
            state_d = WR0;
          end else begin
            state_d = READ;
          end
        end else begin
          cap_valid_s = 1'b0;
        end
      end
      WR0: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = result_addr + RES_FOUND;
        mem_wdata_d = {31'b0, found_s};
        state_d     = WR1;
      end
      WR1: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = result_addr + RES_NONCE;
        mem_wdata_d = 32'(best_s);
        state_d     = WR2;
      end
      WR2: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = result_addr + RES_MIN;
        mem_wdata_d = min_s;
`ifdef NONCE_HIT_COUNT_EN
        state_d     = WR3;
`else
        state_d     = DONE;
`endif
      end
`ifdef NONCE_HIT_COUNT_EN
      WR3: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = result_addr + RES_HITS;
        mem_wdata_d = 32'(hits_s);
        state_d     = DONE;
      end
`endif
      default: begin
        mem_we_d = 1'b0;
        done_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign done               = done_q;
  assign found              = found_s;
  assign best_nonce         = best_s;
  assign mem.mem_clk        = clk;
  assign mem.mem_we         = mem_we_q;
  assign mem.mem_addr       = mem_addr_q;
  assign mem.mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_nonce_result_reader.sv
// Scoreboard bench for nonce_result_reader: directed sweeps with hand-computed records.
module tb_nonce_result_reader;
  import bitcoin_pkg::*;

  localparam int N = 16;
`ifdef NONCE_HIT_COUNT_EN
  localparam int REC_LEN = 4;
  localparam int LAT     = N + 6;
`else
  localparam int REC_LEN = 3;
  localparam int LAT     = N + 5;
`endif

  typedef struct {
    logic [15:0] raddr;
    logic        found;
    logic [7:0]  best;
    logic [31:0] minw;
    logic [8:0]  hits;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] hash_addr = 16'h0000;
  logic [15:0] result_addr = 16'h0000;
  logic [31:0] target = 32'h0000_0000;
  logic        done, found;
  logic [7:0]  best_nonce;

  nonce_result_reader_if mem_if ();

  nonce_result_reader #(.NUM_NONCES(N), .IDX_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .hash_addr   (hash_addr),
    .result_addr (result_addr),
    .target      (target),
    .done        (done),
    .found       (found),
    .best_nonce  (best_nonce),
    .mem         (mem_if)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_arr [0:65535];
  always @(posedge clk) mem_if.mem_read_data <= mem_arr[mem_if.mem_addr];

  exp_t exp_q[$];
  wr_t  wr_log[$];
  int   checks = 0;
  int   errors = 0;
  time  t_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: log writes, and on each done rise pop one expected record and compare
  logic done_prev = 1'b0;
  exp_t e_m;
  logic [31:0] exp_d;
  always @(negedge clk) begin
    if (mem_if.mem_we === 1'b1) wr_log.push_back({mem_if.mem_addr, mem_if.mem_write_data});
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e_m = exp_q.pop_front();
        chk("latency", 32'(($time - t_start - 5) / 10), 32'(LAT));
        chk("found_out", {31'b0, found}, {31'b0, e_m.found});
        chk("best_out", {24'b0, best_nonce}, {24'b0, e_m.best});
        chk("n_writes", 32'(wr_log.size()), 32'(REC_LEN));
        for (int k = 0; k < REC_LEN; k++) begin
          case (k)
            0:       exp_d = {31'b0, e_m.found};
            1:       exp_d = {24'b0, e_m.best};
            2:       exp_d = e_m.minw;
            default: exp_d = {23'b0, e_m.hits};
          endcase
          if (k < wr_log.size()) begin
            chk("wr_addr", {16'b0, wr_log[k].a}, {16'b0, e_m.raddr + 16'(k)});
            chk("wr_data", wr_log[k].d, exp_d);
          end
        end
      end
      wr_log.delete();
    end
    done_prev <= done;
  end

  task automatic run_scan(input logic [15:0] ha, input logic [15:0] ra, input logic [31:0] tg,
                          input exp_t e, input int pulse_at, input int abort_at);
    @(negedge clk);
    hash_addr   = ha;
    result_addr = ra;
    target      = tg;
    start       = 1'b1;
    if (abort_at < 0) exp_q.push_back(e);
    @(posedge clk);
    t_start = $time;
    @(negedge clk);
    start = 1'b0;
    chk("done_clear", {31'b0, done}, 32'd0);
    for (int j = 0; j < N; j++) begin
      if (j > 0) @(negedge clk);
      chk("rd_addr", {16'b0, mem_if.mem_addr}, {16'b0, ha + 16'(j)});
      start = (j == pulse_at);
      if (j == abort_at) break;
    end
    start = 1'b0;
    if (abort_at >= 0) begin
      reset_n = 1'b0;
      #1;
      chk("rst_mem_we", {31'b0, mem_if.mem_we}, 32'd0);
      chk("rst_mem_addr", {16'b0, mem_if.mem_addr}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_found", {31'b0, found}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("abort_no_writes", 32'(wr_log.size()), 32'd0);
      chk("abort_idle", {31'b0, done}, 32'd0);
    end else begin
      for (int w = 0; w < 60 && done !== 1'b1; w++) @(negedge clk);
      chk("done_seen", {31'b0, done}, 32'd1);
    end
  endtask

  logic [31:0] t3 [16];
  logic [15:0] a;

  initial begin
    t3 = '{32'hDEAD_BEEF, 32'h7F00_0001, 32'h0000_1000, 32'hFFFF_FFFE,
           32'h3C3C_3C3C, 32'h0000_0011, 32'h0000_0010, 32'h8000_0000,
           32'h0000_0100, 32'h1234_5678, 32'hCAFE_F00D, 32'h0001_0000,
           32'h0000_0020, 32'h0000_0010, 32'h7777_7777, 32'h0000_0FFF};
    repeat (3) @(negedge clk);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_found", {31'b0, found}, 32'd0);
    chk("reset_best", {24'b0, best_nonce}, 32'd0);
    chk("reset_mem_we", {31'b0, mem_if.mem_we}, 32'd0);
    chk("reset_mem_addr", {16'b0, mem_if.mem_addr}, 32'd0);
    chk("reset_mem_wdata", mem_if.mem_write_data, 32'd0);
    reset_n = 1'b1;

    // Descending words; strict hits only for n=12..15
    for (int n = 0; n < N; n++) mem_arr[16'h0100 + 16'(n)] = 32'h9000_0000 - 32'(n);
    run_scan(16'h0100, 16'h0200, 32'h8FFF_FFF5,
             '{16'h0200, 1'b1, 8'd15, 32'h8FFF_FFF1, 9'd4}, -1, -1);

    // All equal to target: no hits, tie resolves to index 0
    for (int n = 0; n < N; n++) mem_arr[16'h0100 + 16'(n)] = 32'h1234_5678;
    run_scan(16'h0100, 16'h0300, 32'h1234_5678,
             '{16'h0300, 1'b0, 8'd0, 32'h1234_5678, 9'd0}, -1, -1);

    // target=0: never a hit; minimum 0x10 first at n=6
    for (int n = 0; n < N; n++) mem_arr[16'h0100 + 16'(n)] = t3[n];
    run_scan(16'h0100, 16'h0400, 32'h0000_0000,
             '{16'h0400, 1'b0, 8'd6, 32'h0000_0010, 9'd0}, -1, -1);

    // Wrapping sweep: aborted by reset, then rerun to completion
    for (int n = 0; n < N; n++) begin
      a = 16'hFFF8 + 16'(n);
      mem_arr[a] = (n == 10) ? 32'h0000_0042 : 32'h6000_0000 + 32'(n);
    end
    run_scan(16'hFFF8, 16'h0500, 32'h6000_0005,
             '{16'h0500, 1'b0, 8'd0, 32'h0, 9'd0}, -1, 5);
    run_scan(16'hFFF8, 16'h0500, 32'h6000_0005,
             '{16'h0500, 1'b1, 8'd10, 32'h0000_0042, 9'd6}, -1, -1);

    // Restart from DONE with a start pulse mid-READ; minimum tie at n=3 and n=9
    for (int n = 0; n < N; n++)
      mem_arr[16'h0600 + 16'(n)] = (n == 3 || n == 9) ? 32'h0000_0100 : 32'h2000_0000 + 32'(n) * 32'd16;
    run_scan(16'h0600, 16'h0700, 32'h1000_0000,
             '{16'h0700, 1'b1, 8'd3, 32'h0000_0100, 9'd2}, 3, -1);

    // Alternating 1 / FFFFFFFF: eight hits
    for (int n = 0; n < N; n++)
      mem_arr[16'h0800 + 16'(n)] = (n % 2 == 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
    run_scan(16'h0800, 16'h0900, 32'h8000_0000,
             '{16'h0900, 1'b1, 8'd0, 32'h0000_0001, 9'd8}, -1, -1);

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
